// File: rtl/program_loader.sv
// Byte-stream loader for the instruction ROM. It holds the core in reset while an
// image streams in, pads the image to a word boundary, then releases the core after a settle delay.
module program_loader #(
    parameter int ADDR_W         = 8,
    parameter int MAX_BYTES      = 256,
    parameter int RELEASE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_reset,
    output logic              load_done,
    output logic [ADDR_W:0]   byte_count,
    output logic              overflow_err
);

    localparam int CW = $clog2(RELEASE_CYCLES + 2);
    localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W+1)'(MAX_BYTES);

    typedef enum logic [2:0] {IDLE, LOAD, PAD, SETTLE, RUN, ERROR} state_t;

    state_t          state, state_nxt;
    logic [ADDR_W:0] ptr, ptr_inc;
    logic [CW-1:0]   settle_cnt;
    logic            full, accept, pad_wr, clear;

    // The pointer is one bit wider than the ROM address so a full image ends at MAX_BYTES.
    assign ptr_inc = ptr + 1'b1;
    assign full    = (byte_count == MAX_CNT);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        in_ready     = 1'b0;
        cpu_reset    = 1'b1;
        load_done    = 1'b0;
        overflow_err = 1'b0;
        accept       = 1'b0;
        pad_wr       = 1'b0;
        clear        = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    clear     = 1'b1;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                // A byte offered once the image is full is dropped, even if it carries in_last.
                if (in_valid) begin
                    if (full) begin
                        state_nxt = ERROR;
                    end else begin
                        accept = 1'b1;
                        if (in_last) state_nxt = (ptr_inc[1:0] == 2'b00) ? SETTLE : PAD;
                    end
                end
            end
            PAD: begin
                pad_wr = 1'b1;
                if (ptr[1:0] == 2'b11) state_nxt = SETTLE;
            end
            SETTLE: begin
                // SETTLE is entered in the cycle the last write is visible, so counting
                // to RELEASE_CYCLES keeps cpu_reset high for that many cycles afterwards.
                if (settle_cnt == CW'(RELEASE_CYCLES)) state_nxt = RUN;
            end
            RUN: begin
                cpu_reset = 1'b0;
                load_done = 1'b1;
                if (start) begin
                    clear     = 1'b1;
                    state_nxt = LOAD;
                end
            end
            ERROR: begin
                overflow_err = 1'b1;
                if (start) begin
                    clear     = 1'b1;
                    state_nxt = LOAD;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr        <= '0;
            byte_count <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            settle_cnt <= '0;
        end else begin
            mem_we <= accept | pad_wr;
            if (accept || pad_wr) begin
                mem_addr  <= ptr[ADDR_W-1:0];
                mem_wdata <= accept ? in_data : 8'h00;
                ptr       <= ptr_inc;
            end
            if (accept) byte_count <= byte_count + 1'b1;
            if (clear) begin
                ptr        <= '0;
                byte_count <= '0;
            end
            settle_cnt <= (state == SETTLE) ? settle_cnt + 1'b1 : '0;
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: a default instance and a MAX_BYTES=8 instance
// share the stimulus, and sel chooses which one the monitor and the checks observe.
module tb_program_loader;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       sel = 1'b0;

    always #5 clk = ~clk;

    logic       a_ready, a_we, a_cr, a_done, a_ovf;
    logic [7:0] a_addr, a_wdata;
    logic [8:0] a_cnt;
    logic       b_ready, b_we, b_cr, b_done, b_ovf;
    logic [7:0] b_addr, b_wdata;
    logic [8:0] b_cnt;

    program_loader u_dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(a_ready), .mem_we(a_we), .mem_addr(a_addr),
        .mem_wdata(a_wdata), .cpu_reset(a_cr), .load_done(a_done), .byte_count(a_cnt),
        .overflow_err(a_ovf)
    );

    program_loader #(.MAX_BYTES(8)) u_dut8 (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(b_ready), .mem_we(b_we), .mem_addr(b_addr),
        .mem_wdata(b_wdata), .cpu_reset(b_cr), .load_done(b_done), .byte_count(b_cnt),
        .overflow_err(b_ovf)
    );

    logic       ready, we, cr, done, ovf;
    logic [7:0] addr, wdata;
    logic [8:0] cnt;
    assign ready = sel ? b_ready : a_ready;
    assign we    = sel ? b_we    : a_we;
    assign cr    = sel ? b_cr    : a_cr;
    assign done  = sel ? b_done  : a_done;
    assign ovf   = sel ? b_ovf   : a_ovf;
    assign addr  = sel ? b_addr  : a_addr;
    assign wdata = sel ? b_wdata : a_wdata;
    assign cnt   = sel ? b_cnt   : a_cnt;

    logic [31:0] exp_q[$];
    int n_chk = 0, n_fail = 0;
    int n_we = 0, hi_cnt = 0, rel_cnt = -1, exp_ptr = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic last, input logic writes);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        if (writes) begin
            exp_q.push_back(32'({exp_ptr[7:0], d}));
            exp_ptr++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic push_pad();
        while (exp_ptr % 4 != 0) begin
            exp_q.push_back(32'({exp_ptr[7:0], 8'h00}));
            exp_ptr++;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        exp_ptr = 0;
        rel_cnt = -1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done) break;
        end
        #1;
        chk({tag, "_load_done"}, 32'(done), 32'd1);
        chk({tag, "_cpu_reset"}, 32'(cr), 32'd0);
        chk({tag, "_release"}, 32'(rel_cnt), 32'd2);
        chk({tag, "_q_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    logic [7:0] img8 [8] = '{8'hE3, 8'hA0, 8'h10, 8'h05, 8'hE2, 8'h81, 8'h20, 8'h01};

    initial begin
        logic prev_cr;
        logic [31:0] e;
        prev_cr = 1'b1;
        fork
            forever begin
                @(negedge clk);
                if (we === 1'b1) begin
                    n_we++;
                    e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
                    chk("write", 32'({addr, wdata}), e);
                    hi_cnt = 0;
                end else if (cr === 1'b1) begin
                    hi_cnt++;
                end
                if (prev_cr === 1'b1 && cr === 1'b0) rel_cnt = hi_cnt;
                prev_cr = cr;
            end
        join_none

        do_reset();
        @(negedge clk);
        chk("rst_in_ready", 32'(ready), 32'd0);
        chk("rst_mem_we", 32'(we), 32'd0);
        chk("rst_mem_addr", 32'(addr), 32'd0);
        chk("rst_mem_wdata", 32'(wdata), 32'd0);
        chk("rst_cpu_reset", 32'(cr), 32'd1);
        chk("rst_load_done", 32'(done), 32'd0);
        chk("rst_byte_count", 32'(cnt), 32'd0);
        chk("rst_overflow", 32'(ovf), 32'd0);
        @(posedge clk); #1;

        // 8-byte word-aligned image
        pulse_start();
        @(negedge clk);
        chk("t1_in_ready", 32'(ready), 32'd1);
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) send(img8[i], i == 7, 1'b1);
        wait_done("t1");
        chk("t1_byte_count", 32'(cnt), 32'd8);

        // 6-byte image needing two pad bytes
        do_reset();
        pulse_start();
        for (int i = 0; i < 6; i++) send(8'h30 + 8'(i), i == 5, 1'b1);
        push_pad();
        wait_done("t2");
        chk("t2_byte_count", 32'(cnt), 32'd6);

        // 12-byte image with random valid gaps
        do_reset();
        pulse_start();
        n_we = 0;
        for (int i = 0; i < 12; i++) begin
            repeat ($urandom_range(0, 1)) @(posedge clk);
            #1 send(8'($urandom_range(0, 255)), i == 11, 1'b1);
        end
        wait_done("t3");
        chk("t3_we_pulses", 32'(n_we), 32'd12);
        chk("t3_byte_count", 32'(cnt), 32'd12);

        // overflow on the MAX_BYTES=8 instance, in_last on the dropped byte
        sel = 1'b1;
        do_reset();
        pulse_start();
        for (int i = 0; i < 8; i++) send(8'h50 + 8'(i), 1'b0, 1'b1);
        send(8'hAA, 1'b1, 1'b0);
        @(negedge clk);
        chk("t4_overflow", 32'(ovf), 32'd1);
        chk("t4_cpu_reset", 32'(cr), 32'd1);
        chk("t4_load_done", 32'(done), 32'd0);
        chk("t4_in_ready", 32'(ready), 32'd0);
        chk("t4_byte_count", 32'(cnt), 32'd8);
        repeat (3) @(negedge clk);
        chk("t4_q_empty", 32'(exp_q.size()), 32'd0);
        chk("t4_error_held", 32'(ovf), 32'd1);
        @(posedge clk); #1;
        pulse_start();
        @(negedge clk);
        chk("t4_restart_ovf", 32'(ovf), 32'd0);
        chk("t4_restart_ready", 32'(ready), 32'd1);
        chk("t4_restart_cnt", 32'(cnt), 32'd0);
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) send(8'h60 + 8'(i), i == 7, 1'b1);
        wait_done("t4max");
        chk("t4max_overflow", 32'(ovf), 32'd0);
        chk("t4max_byte_count", 32'(cnt), 32'd8);
        sel = 1'b0;

        // reset in the middle of a load
        do_reset();
        pulse_start();
        for (int i = 0; i < 3; i++) send(8'h70 + 8'(i), 1'b0, 1'b1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("t5_byte_count", 32'(cnt), 32'd0);
        chk("t5_mem_we", 32'(we), 32'd0);
        chk("t5_cpu_reset", 32'(cr), 32'd1);
        chk("t5_in_ready", 32'(ready), 32'd0);
        chk("t5_q_empty", 32'(exp_q.size()), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        pulse_start();
        for (int i = 0; i < 4; i++) send(8'h80 + 8'(i), i == 3, 1'b1);
        wait_done("t5");

        // start ignored in LOAD, honoured in RUN
        do_reset();
        pulse_start();
        for (int i = 0; i < 2; i++) send(8'h90 + 8'(i), 1'b0, 1'b1);
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int i = 2; i < 4; i++) send(8'h90 + 8'(i), i == 3, 1'b1);
        wait_done("t6a");
        chk("t6a_byte_count", 32'(cnt), 32'd4);
        pulse_start();
        @(negedge clk);
        chk("t6_run_cpu_reset", 32'(cr), 32'd1);
        chk("t6_run_load_done", 32'(done), 32'd0);
        chk("t6_run_byte_count", 32'(cnt), 32'd0);
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) send(8'hC0 + 8'(i), i == 3, 1'b1);
        wait_done("t6b");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
